dpram_sclk_clr: RTL

Single-clock simple dual-port RAM for the switch packet/descriptor buffers. It is the parametrised successor to the dual-clock RAM and adds:
- per-byte write enables
- selectable read latency
- a selectable read-during-write policy
- a valid strobe on read data
- a hardware clear engine that zero-fills the whole array after reset and on request

The write port and read port are independent but share one clock.

---
 rtl/dpram_sclk_clr.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/dpram_sclk_clr.sv
// Single-clock simple dual-port RAM: byte-lane writes, 1- or 2-cycle read latency,
// selectable read-during-write, zero-fill clear engine. Define DPRAM_SCLK_CLR_PARITY_EN for per-lane parity.
module dpram_sclk_clr #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 16,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  output logic                    busy,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] wbe,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic                    re,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    dout_vld
`ifdef DPRAM_SCLK_CLR_PARITY_EN
  ,
  input  logic                    perr_inj,
  output logic [DATA_WIDTH/8-1:0] rd_perr
`endif
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
`ifdef DPRAM_SCLK_CLR_PARITY_EN
  localparam int PW = DATA_WIDTH + BE_WIDTH;
`else
  localparam int PW = DATA_WIDTH;
`endif

  generate
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
      $error("dpram_sclk_clr: RD_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
      $error("dpram_sclk_clr: DATA_WIDTH must be a multiple of 8");
    end
  endgenerate

  // Handshake: we/re are single-cycle requests taken only while busy=0 (no ready
  // back-pressure); a request seen during busy is dropped. dout_vld pulses once per
  // accepted read; a read presented in cycle N shows in cycle N+RD_LATENCY.

  typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;

  typedef struct packed {
    state_t                state;
    logic [ADDR_WIDTH-1:0] clr_addr;
  } ctl_t;

  ctl_t ctl_q, ctl_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_q <= '{state: CLEAR, clr_addr: '0};
    end else begin
      ctl_q <= ctl_d;
    end
  end

  always_comb begin
    ctl_d = ctl_q;
    case (ctl_q.state)
      CLEAR: begin
        ctl_d.clr_addr = ctl_q.clr_addr + ADDR_WIDTH'(1);
        if (ctl_q.clr_addr == LAST_ADDR) begin
          ctl_d.state = IDLE;
        end
      end
      IDLE: begin
        if (clr) begin
          ctl_d.state    = CLEAR;
          ctl_d.clr_addr = '0;
        end
      end
      default: ctl_d = ctl_q;
    endcase
  end

  assign busy = (ctl_q.state == CLEAR);

  logic wr_acc;
  logic rd_acc;
  logic rdw_hit;

  assign wr_acc  = we & ~busy;
  assign rd_acc  = re & ~busy;
  assign rdw_hit = (RDW_MODE == 1) && wr_acc && (waddr == raddr);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (busy) begin
      mem[ctl_q.clr_addr] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (wbe[i]) begin
          mem[waddr][8*i +: 8] <= din[8*i +: 8];
        end
      end
    end
  end

  logic [DATA_WIDTH-1:0] rd_word;

  always_comb begin
    rd_word = mem[raddr];
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (rdw_hit && wbe[i]) begin
        rd_word[8*i +: 8] = din[8*i +: 8];
      end
    end
  end

  logic [PW-1:0] rd_bus;

`ifdef DPRAM_SCLK_CLR_PARITY_EN
  logic [BE_WIDTH-1:0] par_mem [DEPTH];
  logic [BE_WIDTH-1:0] wr_par;
  logic [BE_WIDTH-1:0] rd_err;

  // Stored bit makes lane+bit even; perr_inj flips it to fake a corrupted lane.
  always_comb begin
    wr_par = '0;
    for (int i = 0; i < BE_WIDTH; i++) begin
      wr_par[i] = (^din[8*i +: 8]) ^ perr_inj;
    end
  end

  always_ff @(posedge clk) begin
    if (busy) begin
      par_mem[ctl_q.clr_addr] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (wbe[i]) begin
          par_mem[waddr][i] <= wr_par[i];
        end
      end
    end
  end

  always_comb begin
    rd_err = '0;
    for (int i = 0; i < BE_WIDTH; i++) begin
      rd_err[i] = ((rdw_hit && wbe[i]) ? wr_par[i] : par_mem[raddr][i])
                  ^ (^rd_word[8*i +: 8]);
    end
  end

  assign rd_bus = {rd_err, rd_word};
`else
  assign rd_bus = rd_word;
`endif

  logic [PW-1:0] out_q;

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [PW-1:0] s1_q;
      logic          s1_vld;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_q     <= '0;
          s1_vld   <= 1'b0;
          out_q    <= '0;
          dout_vld <= 1'b0;
        end else begin
          s1_vld   <= rd_acc;
          if (rd_acc) begin
            s1_q <= rd_bus;
          end
          dout_vld <= s1_vld;
          if (s1_vld) begin
            out_q <= s1_q;
          end
        end
      end
    end else begin : g_lat1
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_q    <= '0;
          dout_vld <= 1'b0;
        end else begin
          dout_vld <= rd_acc;
          if (rd_acc) begin
            out_q <= rd_bus;
          end
        end
      end
    end
  endgenerate

  assign dout = out_q[DATA_WIDTH-1:0];
`ifdef DPRAM_SCLK_CLR_PARITY_EN
  // Error flags are only meaningful alongside a completing read.
  assign rd_perr = out_q[PW-1:DATA_WIDTH] & {BE_WIDTH{dout_vld}};
`endif

endmodule
